// File: rtl/tcdm_synch_pkg.sv
// Shared defaults and per-channel status type for the TCDM completion join.
// No logic; imported by tcdm_synch_fifo and tcdm_synch_n.
package tcdm_synch_pkg;

  localparam int unsigned NB_CHANNELS_DEFAULT = 2;
  localparam int unsigned FIFO_DEPTH_DEFAULT  = 4;
  localparam int unsigned SID_WIDTH_DEFAULT   = 2;

  // Wide enough for any FIFO depth up to 128 entries.
  localparam int unsigned STATUS_CNT_W = 8;

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    full;
    logic                    empty;
  } chan_status_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tcdm_synch_fifo.sv
// Per-channel completion queue, non-fall-through; flush empties it synchronously.
// Latency: push visible at head the cycle after; push accepted when full only if popped in the same cycle.
module tcdm_synch_fifo
  import tcdm_synch_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = SID_WIDTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: head is only consumed when the count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/tcdm_synch_n.sv
// Joins NB_CHANNELS completion streams into one; SID consistency check under TCDM_SYNCH_SID_CHECK_EN.
// Latency: joined completion valid the cycle after the last enabled channel's push.
// Backpressure: valid/sid held while ready is low; pushes to a full channel are dropped and flagged.
module tcdm_synch_n
  import tcdm_synch_pkg::*;
#(
  parameter int unsigned NB_CHANNELS = NB_CHANNELS_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int unsigned SID_WIDTH   = SID_WIDTH_DEFAULT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_CHANNELS-1:0]               chan_en_i,
  input  logic [NB_CHANNELS-1:0]               synch_req_i,
  input  logic [NB_CHANNELS-1:0][SID_WIDTH-1:0] synch_sid_i,
  output logic                                 synch_valid_o,
  input  logic                                 synch_ready_i,
  output logic [SID_WIDTH-1:0]                 synch_sid_o,
  input  logic                                 clr_err_i,
  output logic [NB_CHANNELS-1:0]               overflow_o,
  output logic                                 mismatch_o
);

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic [SID_WIDTH-1:0]   head_sid [NB_CHANNELS];
  logic [CNT_W-1:0]       fifo_cnt [NB_CHANNELS];
  chan_status_t           status   [NB_CHANNELS];
  logic [NB_CHANNELS-1:0] full_vec;
  logic [NB_CHANNELS-1:0] empty_vec;
  logic [NB_CHANNELS-1:0] fifo_full;
  logic [NB_CHANNELS-1:0] fifo_empty;
  logic [NB_CHANNELS-1:0] chan_pop;
  logic [NB_CHANNELS-1:0] ovf_set;
  logic [NB_CHANNELS-1:0] overflow_q;
  logic [SID_WIDTH-1:0]   sel_sid;
  logic                   join_vld;
  logic                   pop_all;

  for (genvar ch = 0; ch < NB_CHANNELS; ch++) begin : g_chan
    tcdm_synch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SID_WIDTH)
    ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .flush    (~chan_en_i[ch]),
      .push     (synch_req_i[ch] & chan_en_i[ch]),
      .pop      (chan_pop[ch]),
      .push_dat (synch_sid_i[ch]),
      .head_dat (head_sid[ch]),
      .full     (fifo_full[ch]),
      .empty    (fifo_empty[ch]),
      .count    (fifo_cnt[ch])
    );

    assign status[ch] = '{count: STATUS_CNT_W'(fifo_cnt[ch]),
                          full:  fifo_full[ch],
                          empty: fifo_empty[ch]};
    assign full_vec[ch]  = status[ch].full;
    assign empty_vec[ch] = status[ch].empty;

    cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      status[ch].count <= STATUS_CNT_W'(FIFO_DEPTH));
  end

  // Disabled channels are don't-care in the join; at least one must be enabled.
  assign join_vld = (|chan_en_i) & (&(~chan_en_i | ~empty_vec));
  assign pop_all  = join_vld & synch_ready_i;
  assign chan_pop = {NB_CHANNELS{pop_all}} & chan_en_i;

  always_comb begin
    sel_sid = '0;
    for (int ch = NB_CHANNELS - 1; ch >= 0; ch--) begin
      if (chan_en_i[ch]) sel_sid = head_sid[ch];
    end
  end

  assign synch_valid_o = join_vld;
  assign synch_sid_o   = join_vld ? sel_sid : '0;

  assign ovf_set = synch_req_i & chan_en_i & full_vec & ~chan_pop;

  // A set event in the clearing cycle survives the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_q <= '0;
    else       overflow_q <= clr_err_i ? ovf_set : (overflow_q | ovf_set);
  end

  assign overflow_o = overflow_q;

`ifdef TCDM_SYNCH_SID_CHECK_EN
  logic [NB_CHANNELS-1:0] sid_ne;
  logic                   mis_set;
  logic                   mismatch_q;

  always_comb begin
    sid_ne = '0;
    for (int ch = 0; ch < NB_CHANNELS; ch++) begin
      sid_ne[ch] = chan_en_i[ch] & (head_sid[ch] != sel_sid);
    end
  end

  assign mis_set = pop_all & (|sid_ne);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mismatch_q <= 1'b0;
    else       mismatch_q <= clr_err_i ? mis_set : (mismatch_q | mis_set);
  end

  assign mismatch_o = mismatch_q;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcdm_synch_n.sv
// Bench for tcdm_synch_n at NB_CHANNELS=3, FIFO_DEPTH=4, SID_WIDTH=2.
module tb_tcdm_synch_n;

  localparam int N = 3;
  localparam int D = 4;
`ifdef TCDM_SYNCH_SID_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     chan_en;
  logic [N-1:0]     synch_req;
  logic [N-1:0][1:0] synch_sid;
  logic             synch_valid;
  logic             synch_ready;
  logic [1:0]       sid_out;
  logic             clr_err;
  logic [N-1:0]     overflow;
  logic             mismatch;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus sticky flags.
  logic [1:0] mq [N][$];
  logic [N-1:0] m_ovf;
  logic         m_mis;

  always #5 clk = ~clk;

  tcdm_synch_n #(.NB_CHANNELS(N), .FIFO_DEPTH(D), .SID_WIDTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .chan_en_i     (chan_en),
    .synch_req_i   (synch_req),
    .synch_sid_i   (synch_sid),
    .synch_valid_o (synch_valid),
    .synch_ready_i (synch_ready),
    .synch_sid_o   (sid_out),
    .clr_err_i     (clr_err),
    .overflow_o    (overflow),
    .mismatch_o    (mismatch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_valid(input logic [N-1:0] en);
    if (en == '0) return 1'b0;
    for (int ch = 0; ch < N; ch++)
      if (en[ch] && mq[ch].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] m_sid(input logic [N-1:0] en);
    if (!m_valid(en)) return 2'd0;
    for (int ch = 0; ch < N; ch++)
      if (en[ch]) return mq[ch][0];
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) mq[ch].delete();
    m_ovf = '0;
    m_mis = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] en, input logic [N-1:0] req,
                            input logic [5:0] sid, input logic rdy, input logic clr);
    logic         pop;
    logic [1:0]   head;
    logic [N-1:0] s_ovf;
    logic         s_mis;
    pop   = m_valid(en) && rdy;
    head  = m_sid(en);
    s_ovf = '0;
    s_mis = 1'b0;
    if (pop && CHK)
      for (int ch = 0; ch < N; ch++)
        if (en[ch] && mq[ch][0] != head) s_mis = 1'b1;
    for (int ch = 0; ch < N; ch++) begin
      if (!en[ch]) mq[ch].delete();
      else begin
        if (pop) void'(mq[ch].pop_front());
        if (req[ch]) begin
          if (mq[ch].size() < D) mq[ch].push_back(sid[2*ch +: 2]);
          else s_ovf[ch] = 1'b1;
        end
      end
    end
    m_ovf = clr ? s_ovf : (m_ovf | s_ovf);
    m_mis = clr ? s_mis : (m_mis | s_mis);
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic cyc(input logic [N-1:0] en, input logic [N-1:0] req,
                     input logic [5:0] sid, input logic rdy, input logic clr);
    chan_en     = en;
    synch_req   = req;
    synch_sid   = sid;
    synch_ready = rdy;
    clr_err     = clr;
    model_step(en, req, sid, rdy, clr);
    @(posedge clk);
    #1;
    chk("model_valid", synch_valid, m_valid(en));
    chk("model_sid", sid_out, m_sid(en));
    chk("model_overflow", overflow, m_ovf);
    chk("model_mismatch", mismatch, m_mis);
  endtask

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] req;
    logic [5:0]   sid;
    logic         rdy;
    logic         clr;
    logic         exp_valid;
    logic [1:0]   exp_sid;
    logic [N-1:0] exp_ovf;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] s;
    logic [1:0] exp_pops [3];

    // Join of three staggered pushes, overflow at depth 4, partial enable, all-disabled.
    vecs[0]  = '{3'b111, 3'b001, 6'b000001, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[1]  = '{3'b111, 3'b010, 6'b000100, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[2]  = '{3'b111, 3'b100, 6'b010000, 1'b1, 1'b0, 1'b1, 2'd1, 3'b000};
    vecs[3]  = '{3'b111, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[4]  = '{3'b111, 3'b001, 6'b000011, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[5]  = '{3'b111, 3'b001, 6'b000011, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[6]  = '{3'b111, 3'b001, 6'b000011, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[7]  = '{3'b111, 3'b001, 6'b000011, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[8]  = '{3'b111, 3'b001, 6'b000011, 1'b0, 1'b0, 1'b0, 2'd0, 3'b001};
    vecs[9]  = '{3'b111, 3'b000, 6'b000000, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000};
    vecs[10] = '{3'b110, 3'b000, 6'b000000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[11] = '{3'b101, 3'b111, 6'b101110, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
    vecs[12] = '{3'b101, 3'b010, 6'b001100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
    vecs[13] = '{3'b101, 3'b010, 6'b001100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
    vecs[14] = '{3'b101, 3'b010, 6'b001100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
    vecs[15] = '{3'b101, 3'b010, 6'b001100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
    vecs[16] = '{3'b101, 3'b010, 6'b001100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
    vecs[17] = '{3'b101, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[18] = '{3'b000, 3'b111, 6'b111111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};

    rst = 1'b1; chan_en = '1; synch_req = '0; synch_sid = '0; synch_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", synch_valid, 1'b0);
    chk("reset_sid", sid_out, 2'd0);
    chk("reset_overflow", overflow, 3'b000);
    chk("reset_mismatch", mismatch, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].en, vecs[i].req, vecs[i].sid, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), synch_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_sid", i), sid_out, vecs[i].exp_sid);
      chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
    end

    // Full channels: pop and push in the same cycle keeps occupancy at 4.
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      cyc(3'b111, 3'b111, {s, s, s}, 1'b0, 1'b0);
    end
    chk("full_valid", synch_valid, 1'b1);
    chk("full_sid", sid_out, 2'd0);
    cyc(3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
    chk("popush_sid", sid_out, 2'd1);
    chk("popush_overflow", overflow, 3'b000);
    exp_pops[0] = 2'd2; exp_pops[1] = 2'd3; exp_pops[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      cyc(3'b111, 3'b000, 6'b000000, 1'b1, 1'b0);
      chk($sformatf("drain%0d_sid", k), sid_out, exp_pops[k]);
    end
    cyc(3'b111, 3'b000, 6'b000000, 1'b1, 1'b0);
    chk("drain_empty", synch_valid, 1'b0);

    // Differing heads on pop.
    cyc(3'b011, 3'b011, 6'b001001, 1'b0, 1'b0);
    chk("mis_sid", sid_out, 2'd1);
    chk("mis_before", mismatch, 1'b0);
    cyc(3'b011, 3'b000, 6'b000000, 1'b1, 1'b0);
    chk("mis_after", mismatch, CHK);
    cyc(3'b011, 3'b000, 6'b000000, 1'b0, 1'b1);
    chk("mis_cleared", mismatch, 1'b0);

    // Asynchronous reset mid-stream with two entries per channel.
    cyc(3'b111, 3'b111, 6'b010101, 1'b0, 1'b0);
    cyc(3'b111, 3'b111, 6'b010101, 1'b0, 1'b0);
    chk("prerst_valid", synch_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", synch_valid, 1'b0);
    chk("rst_async_sid", sid_out, 2'd0);
    synch_req = 3'b111; synch_sid = 6'b101010; synch_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_push_ignored", synch_valid, 1'b0);
    rst = 1'b0;
    model_reset();
    cyc(3'b111, 3'b111, 6'b111111, 1'b0, 1'b0);
    chk("postrst_sid", sid_out, 2'd3);
    cyc(3'b111, 3'b000, 6'b000000, 1'b1, 1'b0);
    chk("postrst_single", synch_valid, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] en;
      logic [5:0]   sid;
      en  = ($urandom_range(0, 9) < 8) ? 3'b111 : 3'($urandom_range(0, 7));
      sid = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        s   = 2'($urandom);
        sid = {s, s, s};
      end
      cyc(en, 3'($urandom), sid, 1'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_synch_n.md
TCDM_SYNCH_N -- requirements
Module: tcdm_synch_n

Interface
REQ-001 SHALL have parameter NB_CHANNELS, default 2, number of completion streams joined (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per channel FIFO (power of two, >=2).
REQ-003 SHALL have parameter SID_WIDTH, default 2, transaction SID width.
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port chan_en_i, input, NB_CHANNELS, channel participates in the join when 1.
REQ-007 SHALL have port synch_req_i, input, NB_CHANNELS, per-channel completion push strobe.
REQ-008 SHALL have port synch_sid_i, input, NB_CHANNELS x SID_WIDTH, per-channel completion SID.
REQ-009 SHALL have port synch_valid_o, output, 1, joined completion available.
REQ-010 SHALL have port synch_ready_i, input, 1, consumer accepts joined completion.
REQ-011 SHALL have port synch_sid_o, output, SID_WIDTH, SID of joined completion.
REQ-012 SHALL have port clr_err_i, input, 1, clears sticky error flags.
REQ-013 SHALL have port overflow_o, output, NB_CHANNELS, sticky per-channel overflow.
REQ-014 SHALL have port mismatch_o, output, 1, sticky SID mismatch flag.

Function
REQ-015 SHALL keep one FIFO per channel with FIFO_DEPTH entries, non-fall-through: a push in cycle t is visible at head no earlier than t+1.
REQ-016 SHALL assert synch_valid_o when at least one chan_en_i bit is 1 and every enabled FIFO is non-empty; all-disabled -> synch_valid_o = 0.
REQ-017 SHALL drive synch_sid_o from the head of the lowest-index enabled channel; 0 when synch_valid_o = 0.
REQ-018 SHALL pop exactly one entry from every enabled FIFO in a cycle where synch_valid_o and synch_ready_i are both 1; no pop otherwise.
REQ-019 SHALL hold synch_valid_o and synch_sid_o stable while synch_valid_o = 1 and synch_ready_i = 0, unless chan_en_i changes.
REQ-020 SHALL accept a push on an enabled channel when not full, or when full and popped in the same cycle.
REQ-021 SHALL drop a push on a full, non-popping enabled channel and set overflow_o[ch] at the next edge; FIFO contents unchanged.
REQ-022 SHALL hold a disabled channel's FIFO flushed (count 0) and drop its pushes without setting overflow_o.
REQ-023 SHALL keep occupancy counters of width clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
REQ-024 SHALL clear all sticky flags on clr_err_i; a set event in the same cycle as clr_err_i wins (flag remains 1).

Reset
REQ-025 SHALL, on rst_i asserted at any time, immediately empty all FIFOs, clear pointers and counters, and force synch_valid_o = 0, synch_sid_o = 0, overflow_o = 0, mismatch_o = 0.
REQ-026 SHALL ignore pushes and ready during reset; first push accepted at the first rising edge after rst_i deasserts.

Configuration
REQ-027 SHALL implement SID consistency checking only when macro TCDM_SYNCH_SID_CHECK_EN is defined.
REQ-028 SHALL, with TCDM_SYNCH_SID_CHECK_EN defined, set mismatch_o at the next edge when a pop occurs and any enabled head SID differs from synch_sid_o.
REQ-029 SHALL, without TCDM_SYNCH_SID_CHECK_EN, tie mismatch_o to 0 and contain no comparison logic.

Structure
REQ-030 SHALL place default parameter constants (NB_CHANNELS, FIFO_DEPTH, SID_WIDTH) and the per-channel status typedef (count, full, empty) in package tcdm_synch_pkg.
REQ-031 SHALL implement the per-channel queue as sub-module tcdm_synch_fifo (push, pop, flush, data, full, empty), instantiated NB_CHANNELS times.

Verification
REQ-032 SHALL test: NB_CHANNELS=3, all enabled, ready=1; push SID 1 on ch0 t0, ch1 t1, ch2 t2 -> synch_valid_o=1 at t3 with SID 1 for one cycle.
REQ-033 SHALL test: ready=0, fill ch0 with 5 pushes at FIFO_DEPTH=4 -> overflow_o[0]=1 after 5th push; clr_err_i -> 0.
REQ-034 SHALL test: chan_en_i=3'b101, push ch0 and ch2 SID 2, push ch1 -> valid with SID 2, ch1 never fills, no overflow.
REQ-035 SHALL test: full channel, valid&ready and push same cycle -> push accepted, count stays 4.
REQ-036 SHALL test (macro defined): heads ch0=1, ch1=2, pop -> synch_sid_o=1, mismatch_o=1 next cycle; macro undefined -> mismatch_o=0.
REQ-037 SHALL test: rst_i asserted mid-stream with 2 entries per FIFO -> synch_valid_o=0 immediately, fresh pushes restart at count 0.
